// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring divider (one quotient bit per clock) with optional
//   two's-complement operation, divide-by-zero detection and, when the macro
//   SEQ_DIVIDER_EARLY_OUT_EN is defined, an early-out path for |A| < |B|.
//
// Parameters
//   WIDTH      operand/result width (4..64)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset, priority over everything
//   start      request pulse, only sampled while busy = 0
//   signed_op  1 = signed divide, 0 = unsigned divide (latched with start)
//   srcA       dividend (latched with start)
//   srcB       divisor  (latched with start)
//   busy       high from the accepting edge until the edge that raises done
//   done       one-cycle pulse marking valid results
//   divZero    set when the accepted divisor was zero
//   hi         remainder (sign of the dividend)
//   lo         quotient (truncated toward zero)
//
// Configuration
//   SEQ_DIVIDER_EARLY_OUT_EN  when defined, |A| < |B| skips the iteration.
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH:0]     rem_q, rem_d;     // partial remainder, one guard bit
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;     // dividend magnitude, shifted out MSB-first
  logic [WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               bz_q, bz_d;       // accepted divisor was zero

  logic               a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH+1:0]   shifted_s;
  logic [WIDTH:0]     diff_s;
  logic               ge_s;

  // Operand magnitudes and one restoring step of the datapath
  always_comb begin
    a_neg_s   = signed_op & srcA[WIDTH-1];
    b_neg_s   = signed_op & srcB[WIDTH-1];
    mag_a_s   = a_neg_s ? (~srcA + {{(WIDTH-1){1'b0}}, 1'b1}) : srcA;
    mag_b_s   = b_neg_s ? (~srcB + {{(WIDTH-1){1'b0}}, 1'b1}) : srcB;
    shifted_s = {rem_q, dvd_q[WIDTH-1]};
    ge_s      = (shifted_s >= {2'b00, dvs_q});
    diff_s    = shifted_s[WIDTH:0] - {1'b0, dvs_q};
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    bz_d       = bz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d      = mag_a_s;
          dvs_d      = mag_b_s;
          rem_d      = {(WIDTH+1){1'b0}};
          quot_d     = {WIDTH{1'b0}};
          cnt_d      = {CNT_W{1'b0}};
          qneg_d     = a_neg_s ^ b_neg_s;
          rneg_d     = a_neg_s;
          div_zero_d = 1'b0;
          busy_d     = 1'b1;
          bz_d       = (srcB == {WIDTH{1'b0}});
          if (srcB == {WIDTH{1'b0}}) begin
            state_d = ST_FIN;
          end
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
          else if (mag_a_s < mag_b_s) begin
            // Quotient is zero; the remainder is |A| and FIN restores its sign.
            rem_d   = {1'b0, mag_a_s};
            state_d = ST_FIN;
          end
`endif
          else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        rem_d  = ge_s ? diff_s : shifted_s[WIDTH:0];
        quot_d = {quot_q[WIDTH-2:0], ge_s};
        dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (bz_q) begin
          // Divide by zero: flag it and leave the previous results in place.
          div_zero_d = 1'b1;
        end else begin
          lo_d = qneg_q ? (~quot_q + {{(WIDTH-1){1'b0}}, 1'b1}) : quot_q;
          hi_d = rneg_q ? (~rem_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                        : rem_q[WIDTH-1:0];
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      rem_q      <= {(WIDTH+1){1'b0}};
      quot_q     <= {WIDTH{1'b0}};
      dvd_q      <= {WIDTH{1'b0}};
      dvs_q      <= {WIDTH{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      bz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      bz_q       <= bz_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign divZero = div_zero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Directed self-checking bench for seq_divider (WIDTH = 32). Inputs are
//   driven on the falling edge, outputs sampled 1 ns after the rising edge.
//   Latencies are counted in rising edges after the accepting edge (edge 0).
// -----------------------------------------------------------------------------
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        done;
  logic        divZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .srcA      (srcA),
    .srcB      (srcB),
    .busy      (busy),
    .done      (done),
    .divZero   (divZero),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start one operation; lat = edge index of done (-1 if it never came).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, output int lat, output logic busy_acc);
    @(negedge clk);
    srcA = a; srcB = b; signed_op = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_acc = busy;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, divZero, hi, lo} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h, want all 0",
               busy, done, divZero, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat; logic ba;
    run_op(32'd100, 32'd7, 1'b0, lat, ba);
    n_tests++;
    if (ba !== 1'b1) begin n_fail++; $display("FAIL u100_7_busy: got %b want 1", ba); end
    n_tests++;
    if (lat !== 33) begin n_fail++; $display("FAIL u100_7_lat: got %0d want 33", lat); end
    n_tests++;
    if (lo !== 32'd14 || hi !== 32'd2 || divZero !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL u100_7_res: lo=%0d hi=%0d dz=%b busy=%b want 14 2 0 0", lo, hi, divZero, busy);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b lo=%0d hi=%0d want 0 14 2", done, lo, hi);
    end
    run_op(32'hFFFF_FFFF, 32'd2, 1'b0, lat, ba);
    n_tests++;
    if (lo !== 32'h7FFF_FFFF || hi !== 32'd1 || lat !== 33) begin
      n_fail++;
      $display("FAIL uMAX_2: lo=%h hi=%h lat=%0d want 7fffffff 1 33", lo, hi, lat);
    end
  endtask

  task automatic test_signed();
    int lat; logic ba;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat, ba);
    n_tests++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || lat !== 33) begin
      n_fail++;
      $display("FAIL s_m7_2: lo=%h hi=%h lat=%0d want fffffffd ffffffff 33", lo, hi, lat);
    end
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, lat, ba);
    n_tests++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
      n_fail++;
      $display("FAIL s_7_m2: lo=%h hi=%h want fffffffd 00000001", lo, hi);
    end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, ba);
    n_tests++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0 || lat !== 33 || divZero !== 1'b0) begin
      n_fail++;
      $display("FAIL s_min_m1: lo=%h hi=%h lat=%0d dz=%b want 80000000 0 33 0", lo, hi, lat, divZero);
    end
    // Same bits unsigned: 0x80000000 / 0xFFFFFFFF = 0 rem 0x80000000
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, ba);
    n_tests++;
    if (lo !== 32'd0 || hi !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL u_min_max: lo=%h hi=%h want 0 80000000", lo, hi);
    end
  endtask

  task automatic test_div_zero();
    int lat; logic ba;
    run_op(32'd100, 32'd7, 1'b0, lat, ba);
    run_op(32'd55, 32'd0, 1'b0, lat, ba);
    n_tests++;
    if (lat !== 1 || divZero !== 1'b1 || lo !== 32'd14 || hi !== 32'd2) begin
      n_fail++;
      $display("FAIL div_zero: lat=%0d dz=%b lo=%0d hi=%0d want 1 1 14 2", lat, divZero, lo, hi);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || divZero !== 1'b1) begin
      n_fail++;
      $display("FAIL div_zero_hold: done=%b dz=%b want 0 1", done, divZero);
    end
    run_op(32'd20, 32'd6, 1'b0, lat, ba);
    n_tests++;
    if (divZero !== 1'b0 || lo !== 32'd3 || hi !== 32'd2) begin
      n_fail++;
      $display("FAIL dz_clear: dz=%b lo=%0d hi=%0d want 0 3 2", divZero, lo, hi);
    end
  endtask

  task automatic test_early_out();
    int lat; logic ba; int exp_lat;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    exp_lat = 1;
`else
    exp_lat = 33;
`endif
    run_op(32'd5, 32'd9, 1'b0, lat, ba);
    n_tests++;
    if (lat !== exp_lat || lo !== 32'd0 || hi !== 32'd5) begin
      n_fail++;
      $display("FAIL small_u: lat=%0d lo=%0d hi=%0d want %0d 0 5", lat, lo, hi, exp_lat);
    end
    run_op(32'hFFFF_FFFB, 32'd9, 1'b1, lat, ba);
    n_tests++;
    if (lat !== exp_lat || lo !== 32'd0 || hi !== 32'hFFFF_FFFB) begin
      n_fail++;
      $display("FAIL small_s: lat=%0d lo=%h hi=%h want %0d 0 fffffffb", lat, lo, hi, exp_lat);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    srcA = 32'd100; srcB = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      if (i == 5) begin
        srcA = 32'd1000; srcB = 32'd3; signed_op = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    n_tests++;
    if (lat !== 33 || lo !== 32'd14 || hi !== 32'd2) begin
      n_fail++;
      $display("FAIL busy_ignore: lat=%0d lo=%0d hi=%0d want 33 14 2", lat, lo, hi);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic ba; logic seen;
    @(negedge clk);
    srcA = 32'd100; srcB = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;                 // edge 0
    start = 1'b0;
    repeat (9) @(posedge clk);          // edges 1..9
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;                 // edge 10
    n_tests++;
    if ({busy, done, divZero, hi, lo} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
               busy, done, divZero, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abandon: done/busy seen=%b want 0", seen);
    end
    run_op(32'd9, 32'd3, 1'b0, lat, ba);
    n_tests++;
    if (lo !== 32'd3 || hi !== 32'd0 || lat !== 33) begin
      n_fail++;
      $display("FAIL after_reset: lo=%0d hi=%0d lat=%0d want 3 0 33", lo, hi, lat);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; srcA = 32'd0; srcB = 32'd0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_early_out();
    test_busy_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
